// File: rtl/div32_seq.sv
// Sequential 32-bit integer divider (non-restoring, one quotient bit per cycle).
// Every add/subtract on the partial remainder goes through a single addsub32.
// Signed operands are reduced to magnitudes on accept and the signs are applied
// in the FIX cycle. A zero divisor yields q = all ones, r = original dividend.

module addsub32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] s,
  output logic        cout
);
  // a + b when sub = 0, a - b (a + ~b + 1) when sub = 1
  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, b ^ {32{sub}}} + {32'd0, sub};
  end
endmodule

module div32_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             ready,
  output logic             dz
);
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t           state, state_nx;
  logic [4:0]       cnt;
  logic [WIDTH:0]   rem;      // partial remainder: sign bit + 32-bit value
  logic [WIDTH-1:0] qd;       // dividend shifts out the top, quotient bits enter the bottom
  logic [WIDTH-1:0] dvs;      // divisor magnitude
  logic [WIDTH-1:0] a_org;    // un-negated dividend for the divide-by-zero result
  logic             neg_q;
  logic             neg_r;
  logic             dz_lat;

  logic [WIDTH-1:0] as_a;
  logic             as_sub;
  logic [WIDTH-1:0] as_s;
  logic             as_c;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] rmag;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  addsub32 u_addsub (
    .a    (as_a),
    .b    (dvs),
    .sub  (as_sub),
    .s    (as_s),
    .cout (as_c)
  );

  // Adder operand select: shifted remainder during ITER, final correction in FIX
  always_comb begin
    as_a   = {rem[WIDTH-2:0], qd[WIDTH-1]};
    as_sub = ~rem[WIDTH];
    if (state == FIX) begin
      as_a   = rem[WIDTH-1:0];
      as_sub = 1'b0;
    end
  end

  // Result sign bit is the 33-bit sign extension: shifted sign ^ extended operand sign ^ carry.
  // The shifted value's top bit is rem[31]; its 34th bit is redundant because |rem| < divisor.
  always_comb begin
    rem_step = {rem[WIDTH-1] ^ as_sub ^ as_c, as_s};
    rmag     = rem[WIDTH] ? as_s : rem[WIDTH-1:0];
    q_fin    = neg_q ? (~qd + 1'b1) : qd;
    r_fin    = neg_r ? (~rmag + 1'b1) : rmag;
  end

  // State register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    ready    = 1'b0;
    case (state)
      IDLE: if (start) state_nx = ITER;
      ITER: begin
        busy = 1'b1;
        if (cnt == 5'd31) state_nx = FIX;
      end
      FIX: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        ready    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and result registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt    <= '0;
      rem    <= '0;
      qd     <= '0;
      dvs    <= '0;
      a_org  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz_lat <= 1'b0;
      q      <= '0;
      r      <= '0;
      dz     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          qd     <= (sign && a[WIDTH-1]) ? (~a + 1'b1) : a;
          dvs    <= (sign && b[WIDTH-1]) ? (~b + 1'b1) : b;
          a_org  <= a;
          neg_q  <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r  <= sign & a[WIDTH-1];
          dz_lat <= (b == '0);
          rem    <= '0;
          cnt    <= '0;
        end
        ITER: begin
          rem <= rem_step;
          qd  <= {qd[WIDTH-2:0], ~rem_step[WIDTH]};
          cnt <= cnt + 5'd1;
        end
        FIX: begin
          if (dz_lat) begin
            q <= '1;
            r <= a_org;
          end else begin
            q <= q_fin;
            r <= r_fin;
          end
          dz <= dz_lat;
        end
        default: ;
      endcase
    end
  end
endmodule
